// File: rtl/cmp_col_max_n_if.sv
// Beat/result bundle for the column-maximum tracker.
// The master drives beats in and observes the running maximum; the slave is the tracker.
interface cmp_col_max_n_if #(
    parameter int unsigned SCORE_WIDTH    = 16,
    parameter int unsigned LOCATION_WIDTH = 32,
    parameter int unsigned NUM_LANES      = 4,
    parameter int unsigned CNT_WIDTH      = 16
) ();
    localparam int unsigned LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    logic                                in_valid;
    logic [NUM_LANES-1:0]                lane_mask;
    logic [NUM_LANES*SCORE_WIDTH-1:0]    value_in;
    logic [NUM_LANES*LOCATION_WIDTH-1:0] location_in;
    logic [SCORE_WIDTH-1:0]              max_out;
    logic [LOCATION_WIDTH-1:0]           location_out;
    logic [LANE_W-1:0]                   lane_out;
    logic                                out_valid;
    logic [CNT_WIDTH-1:0]                sample_cnt;

    modport master (
        output in_valid, lane_mask, value_in, location_in,
        input  max_out, location_out, lane_out, out_valid, sample_cnt
    );

    modport slave (
        input  in_valid, lane_mask, value_in, location_in,
        output max_out, location_out, lane_out, out_valid, sample_cnt
    );
endinterface

// File: rtl/cmp_col_max_n.sv
// N-lane column-maximum tracker: alignment delay line, pipelined pairwise compare tree,
// and a clearable running maximum with its location and lane.
module cmp_col_max_n #(
    parameter int unsigned SCORE_WIDTH    = 16,
    parameter int unsigned LOCATION_WIDTH = 32,
    parameter int unsigned NUM_LANES      = 4,
    parameter int unsigned DELAY          = 6,
    parameter int unsigned TIE_MODE       = 0,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    input  logic           clear,
    cmp_col_max_n_if.slave bus
);
    localparam int unsigned TREE_STAGES = $clog2(NUM_LANES);
    localparam int unsigned PAD_LANES   = 1 << TREE_STAGES;
    localparam int unsigned LANE_W      = (TREE_STAGES == 0) ? 1 : TREE_STAGES;
    localparam logic signed [SCORE_WIDTH-1:0] SMIN = {1'b1, {(SCORE_WIDTH-1){1'b0}}};

    typedef struct packed {
        logic                          vld;
        logic signed [SCORE_WIDTH-1:0] score;
        logic [LOCATION_WIDTH-1:0]     loc;
        logic [LANE_W-1:0]             lane;
    } node_t;

    // a is always the lower lane index, so it keeps ties.
    function automatic node_t pick(input node_t a, input node_t b);
        if (b.vld && (!a.vld || ($signed(b.score) > $signed(a.score)))) begin
            return b;
        end
        return a;
    endfunction

    node_t dl_in [NUM_LANES];
    node_t dl_q  [DELAY][NUM_LANES];
    node_t lv0   [PAD_LANES];
    node_t tree_out;

    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            dl_in[i].vld   = bus.in_valid & bus.lane_mask[i];
            dl_in[i].score = bus.lane_mask[i] ? bus.value_in[i*SCORE_WIDTH +: SCORE_WIDTH] : SMIN;
            dl_in[i].loc   = bus.location_in[i*LOCATION_WIDTH +: LOCATION_WIDTH];
            dl_in[i].lane  = LANE_W'(i);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int s = 0; s < DELAY; s++) begin
                for (int i = 0; i < NUM_LANES; i++) begin
                    dl_q[s][i] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                dl_q[0][i] <= dl_in[i];
            end
            for (int s = 1; s < DELAY; s++) begin
                for (int i = 0; i < NUM_LANES; i++) begin
                    dl_q[s][i] <= dl_q[s-1][i];
                end
            end
        end
    end

    // Pad lanes stay all-zero, i.e. invalid.
    always_comb begin
        for (int j = 0; j < PAD_LANES; j++) begin
            lv0[j] = '0;
        end
        for (int j = 0; j < NUM_LANES; j++) begin
            lv0[j] = dl_q[DELAY-1][j];
        end
    end

    if (TREE_STAGES > 0) begin : g_tree
        node_t tr_in [TREE_STAGES][PAD_LANES];
        node_t tr_d  [TREE_STAGES][PAD_LANES];
        node_t tr_q  [TREE_STAGES][PAD_LANES];

        always_comb begin
            for (int j = 0; j < PAD_LANES; j++) begin
                tr_in[0][j] = lv0[j];
            end
            for (int k = 1; k < TREE_STAGES; k++) begin
                for (int j = 0; j < PAD_LANES; j++) begin
                    tr_in[k][j] = tr_q[k-1][j];
                end
            end
        end

        // Every level is computed full width; only the low half of each level is meaningful.
        always_comb begin
            for (int k = 0; k < TREE_STAGES; k++) begin
                for (int j = 0; j < PAD_LANES; j++) begin
                    tr_d[k][j] = '0;
                end
                for (int j = 0; j < PAD_LANES / 2; j++) begin
                    tr_d[k][j] = pick(tr_in[k][2*j], tr_in[k][2*j+1]);
                end
            end
        end

        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                for (int k = 0; k < TREE_STAGES; k++) begin
                    for (int j = 0; j < PAD_LANES; j++) begin
                        tr_q[k][j] <= '0;
                    end
                end
            end else begin
                for (int k = 0; k < TREE_STAGES; k++) begin
                    for (int j = 0; j < PAD_LANES; j++) begin
                        tr_q[k][j] <= tr_d[k][j];
                    end
                end
            end
        end

        assign tree_out = tr_q[TREE_STAGES-1][0];
    end else begin : g_no_tree
        assign tree_out = lv0[0];
    end

    logic signed [SCORE_WIDTH-1:0] max_d, max_q;
    logic [LOCATION_WIDTH-1:0]     loc_d, loc_q;
    logic [LANE_W-1:0]             lane_d, lane_q;
    logic                          ov_d, ov_q;
    logic [CNT_WIDTH-1:0]          cnt_d, cnt_q;

    always_comb begin
        max_d  = max_q;
        loc_d  = loc_q;
        lane_d = lane_q;
        cnt_d  = cnt_q;
        ov_d   = 1'b0;
        if (clear) begin
            if (tree_out.vld) begin
                max_d  = tree_out.score;
                loc_d  = tree_out.loc;
                lane_d = tree_out.lane;
                cnt_d  = CNT_WIDTH'(1);
                ov_d   = 1'b1;
            end else begin
                max_d  = SMIN;
                loc_d  = '0;
                lane_d = '0;
                cnt_d  = '0;
            end
        end else if (tree_out.vld) begin
            ov_d = 1'b1;
            if (($signed(tree_out.score) > max_q) ||
                ((TIE_MODE == 1) && ($signed(tree_out.score) == max_q))) begin
                max_d  = tree_out.score;
                loc_d  = tree_out.loc;
                lane_d = tree_out.lane;
            end
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            max_q  <= SMIN;
            loc_q  <= '0;
            lane_q <= '0;
            ov_q   <= 1'b0;
            cnt_q  <= '0;
        end else begin
            max_q  <= max_d;
            loc_q  <= loc_d;
            lane_q <= lane_d;
            ov_q   <= ov_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.max_out      = max_q;
    assign bus.location_out = loc_q;
    assign bus.lane_out     = lane_q;
    assign bus.out_valid    = ov_q;
    assign bus.sample_cnt   = cnt_q;
endmodule

// File: tb/tb_cmp_col_max_n.sv
// Directed bench for cmp_col_max_n: default config, TIE_MODE=1 twin, and a 1-lane/1-deep build.
module tb_cmp_col_max_n;
    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    logic clear     = 1'b0;
    int   n_vec     = 0;
    int   n_err     = 0;

    always #5 sys_clk = ~sys_clk;

    cmp_col_max_n_if bus0 ();
    cmp_col_max_n_if bus1 ();
    cmp_col_max_n_if #(.NUM_LANES(1)) bus2 ();

    assign bus1.in_valid    = bus0.in_valid;
    assign bus1.lane_mask   = bus0.lane_mask;
    assign bus1.value_in    = bus0.value_in;
    assign bus1.location_in = bus0.location_in;

    cmp_col_max_n dut0 (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clear     (clear),
        .bus       (bus0)
    );

    cmp_col_max_n #(.TIE_MODE(1)) dut1 (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clear     (clear),
        .bus       (bus1)
    );

    cmp_col_max_n #(.NUM_LANES(1), .DELAY(1)) dut2 (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clear     (clear),
        .bus       (bus2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic waitn(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] m, input int s0, input int s1, input int s2,
                         input int s3, input int base);
        int s [4];
        s = '{s0, s1, s2, s3};
        bus0.in_valid  = 1'b1;
        bus0.lane_mask = m;
        for (int i = 0; i < 4; i++) begin
            bus0.value_in[i*16 +: 16]    = s[i][15:0];
            bus0.location_in[i*32 +: 32] = base + i;
        end
    endtask

    task automatic idle();
        bus0.in_valid  = 1'b0;
        bus0.lane_mask = 4'b0000;
    endtask

    initial begin
        idle();
        bus0.value_in    = '0;
        bus0.location_in = '0;
        bus2.in_valid    = 1'b0;
        bus2.lane_mask   = 1'b0;
        bus2.value_in    = '0;
        bus2.location_in = '0;

        #12;
        chk("rst_max", bus0.max_out, 16'h8000);
        chk("rst_loc", bus0.location_out, 0);
        chk("rst_lane", bus0.lane_out, 0);
        chk("rst_ov", bus0.out_valid, 0);
        chk("rst_cnt", bus0.sample_cnt, 0);
        chk("rst_max_n1", bus2.max_out, 16'h8000);
        #10 sys_rst_n = 1'b1;
        waitn(2);

        // Single beat, latency 9.
        drive(4'b1111, 3, -2, 7, 5, 100);
        waitn(1);
        idle();
        waitn(7);
        chk("t1_ov_early", bus0.out_valid, 0);
        waitn(1);
        chk("t1_ov", bus0.out_valid, 1);
        chk("t1_max", bus0.max_out, 7);
        chk("t1_loc", bus0.location_out, 102);
        chk("t1_lane", bus0.lane_out, 2);
        chk("t1_cnt", bus0.sample_cnt, 1);
        waitn(1);
        chk("t1_ov_late", bus0.out_valid, 0);

        // Clear with nothing arriving.
        clear = 1'b1;
        waitn(1);
        clear = 1'b0;
        chk("clr_max", bus0.max_out, 16'h8000);
        chk("clr_loc", bus0.location_out, 0);
        chk("clr_cnt", bus0.sample_cnt, 0);
        chk("clr_ov", bus0.out_valid, 0);

        // Back-to-back beats 4, 9, 9, 2.
        drive(4'b1111, 4, 1, 0, -1, 10);
        waitn(1);
        drive(4'b1111, 9, 3, -4, 0, 50);
        waitn(1);
        drive(4'b1111, 9, 2, 1, 8, 60);
        waitn(1);
        drive(4'b1111, 2, -7, 1, 0, 70);
        waitn(1);
        idle();
        waitn(5);
        chk("b2b_max0", bus0.max_out, 4);
        chk("b2b_loc0", bus0.location_out, 10);
        chk("b2b_cnt0", bus0.sample_cnt, 1);
        waitn(1);
        chk("b2b_max1", bus0.max_out, 9);
        chk("b2b_loc1", bus0.location_out, 50);
        waitn(1);
        chk("b2b_max2", bus0.max_out, 9);
        chk("b2b_loc2", bus0.location_out, 50);
        chk("b2b_tie1_loc2", bus1.location_out, 60);
        waitn(1);
        chk("b2b_max3", bus0.max_out, 9);
        chk("b2b_loc3", bus0.location_out, 50);
        chk("b2b_cnt3", bus0.sample_cnt, 4);
        chk("b2b_ov3", bus0.out_valid, 1);
        chk("b2b_tie1_loc3", bus1.location_out, 60);
        chk("b2b_tie1_cnt3", bus1.sample_cnt, 4);

        // Single-lane mask.
        clear = 1'b1;
        waitn(1);
        clear = 1'b0;
        drive(4'b0001, -5, 100, 50, 50, 200);
        waitn(1);
        idle();
        waitn(8);
        chk("mask_max", bus0.max_out, 16'hFFFB);
        chk("mask_lane", bus0.lane_out, 0);
        chk("mask_loc", bus0.location_out, 200);
        chk("mask_cnt", bus0.sample_cnt, 1);

        // Empty mask is dropped.
        drive(4'b0000, 100, 100, 100, 100, 0);
        waitn(1);
        idle();
        waitn(8);
        chk("drop_ov", bus0.out_valid, 0);
        chk("drop_cnt", bus0.sample_cnt, 1);
        chk("drop_max", bus0.max_out, 16'hFFFB);

        // All lanes tie inside the tree.
        drive(4'b1111, 8, 8, 8, 8, 7);
        waitn(1);
        idle();
        waitn(8);
        chk("tie_max", bus0.max_out, 8);
        chk("tie_lane", bus0.lane_out, 0);
        chk("tie_loc", bus0.location_out, 7);
        chk("tie_cnt", bus0.sample_cnt, 2);
        chk("tie_tie1_lane", bus1.lane_out, 0);
        chk("tie_tie1_loc", bus1.location_out, 7);

        // Clear lands in the same cycle as a lower sample.
        drive(4'b1111, 20, 1, 2, 3, 300);
        waitn(1);
        idle();
        waitn(8);
        chk("col_max20", bus0.max_out, 20);
        chk("col_cnt3", bus0.sample_cnt, 3);
        drive(4'b1111, -3, -10, -20, -30, 400);
        waitn(1);
        idle();
        waitn(7);
        clear = 1'b1;
        waitn(1);
        clear = 1'b0;
        chk("col_max", bus0.max_out, 16'hFFFD);
        chk("col_cnt", bus0.sample_cnt, 1);
        chk("col_ov", bus0.out_valid, 1);
        chk("col_loc", bus0.location_out, 400);

        // One lane, one delay stage: latency 2.
        bus2.in_valid    = 1'b1;
        bus2.lane_mask   = 1'b1;
        bus2.value_in    = 16'd11;
        bus2.location_in = 32'd55;
        waitn(1);
        bus2.in_valid    = 1'b0;
        bus2.lane_mask   = 1'b0;
        chk("n1_ov_early", bus2.out_valid, 0);
        waitn(1);
        chk("n1_ov", bus2.out_valid, 1);
        chk("n1_max", bus2.max_out, 11);
        chk("n1_lane", bus2.lane_out, 0);
        chk("n1_loc", bus2.location_out, 55);
        chk("n1_cnt", bus2.sample_cnt, 1);
        waitn(1);
        chk("n1_ov_late", bus2.out_valid, 0);

        // Reset with five beats in flight.
        for (int i = 0; i < 5; i++) begin
            drive(4'b1111, 50 + i, 0, 0, 0, 500 + i);
            waitn(1);
        end
        idle();
        #2 sys_rst_n = 1'b0;
        #1;
        chk("mrst_max", bus0.max_out, 16'h8000);
        chk("mrst_loc", bus0.location_out, 0);
        chk("mrst_lane", bus0.lane_out, 0);
        chk("mrst_ov", bus0.out_valid, 0);
        chk("mrst_cnt", bus0.sample_cnt, 0);
        chk("mrst_max_n1", bus2.max_out, 16'h8000);
        waitn(2);
        sys_rst_n = 1'b1;
        for (int i = 0; i < 11; i++) begin
            waitn(1);
            chk("mrst_no_ov", bus0.out_valid, 0);
            chk("mrst_no_cnt", bus0.sample_cnt, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/cmp_col_max_n.md
Name: cmp_col_max_n

Overview:
- Parametrised column-maximum tracker for the cigar/alignment scoring path.
- Accepts NUM_LANES signed score/location pairs per cycle and aligns them through a configurable delay line.
- Reduces the lanes to one winner in a pipelined compare tree, then keeps a running maximum with its location until cleared.
- Generalises the fixed 6-deep, 2-input column compare to N lanes, a programmable depth, a lane mask and a selectable tie policy.

Parameters:
- SCORE_WIDTH, 16: signed score width.
- LOCATION_WIDTH, 32: location tag width.
- NUM_LANES, 4: lanes per input beat, >=1.
- DELAY, 6: alignment register stages before the tree, >=1; includes the input register.
- TIE_MODE, 0: 0 = an equal score keeps the incumbent; 1 = an equal score replaces the incumbent.
- CNT_WIDTH, 16: sample counter width.
- Derived: TREE_STAGES = clog2(NUM_LANES), which is 0 when NUM_LANES=1. LANE_W = max(1, clog2(NUM_LANES)). L = DELAY + TREE_STAGES + 1.

Ports:
- sys_clk, in, 1: clock.
- sys_rst_n, in, 1: asynchronous active-low reset.
- clear, in, 1: synchronous restart of the running maximum.
- in_valid, in, 1: the input beat is valid.
- lane_mask, in, NUM_LANES: per-lane enable; bit i covers lane i.
- value_in, in, NUM_LANES*SCORE_WIDTH: packed signed scores; lane i occupies bits [i*SW +: SW].
- location_in, in, NUM_LANES*LOCATION_WIDTH: packed locations, same packing.
- max_out, out, SCORE_WIDTH: running maximum score.
- location_out, out, LOCATION_WIDTH: location of max_out.
- lane_out, out, LANE_W: lane index that produced max_out.
- out_valid, out, 1: one-cycle pulse when the accumulator absorbs a sample.
- sample_cnt, out, CNT_WIDTH: number of samples absorbed since reset or clear.

Behaviour:
- Reset: sys_rst_n is asynchronous, active-low; the clock is sys_clk. Reset applies to every register, pipeline included.
  - max_out = SMIN, where SMIN is the most negative value, -2^(SW-1).
  - location_out = 0, lane_out = 0, out_valid = 0, sample_cnt = 0.
  - All pipeline valids and data are 0.
- Input acceptance:
  - A beat enters when in_valid=1 and lane_mask != 0.
  - A beat with in_valid=1 and lane_mask = 0 is dropped: no out_valid, no count.
  - Masked lanes enter the tree as score SMIN, carrying an invalid flag.
- Delay line:
  - DELAY registers carry valid, masked scores, locations and lane flags unchanged.
  - There is no enable; the line shifts every cycle.
- Compare tree:
  - TREE_STAGES registered levels of pairwise compare.
  - A valid lane beats an invalid lane.
  - Between two valid lanes, the strictly greater signed score wins; on a tie, the lower lane index wins regardless of TIE_MODE.
  - The winner carries its score, location and lane index.
  - Pad lanes for non-power-of-2 NUM_LANES are invalid.
- Accumulator, evaluated at the tree output in each cycle:
  - If clear=1 and the tree output is valid: load the sample unconditionally, set sample_cnt=1, out_valid=1.
  - If clear=1 and the tree output is invalid: max_out=SMIN, location_out=0, lane_out=0, sample_cnt=0, out_valid=0.
  - Otherwise, if the tree output is valid: replace the incumbent when score > max_out, or when TIE_MODE=1 and score == max_out. sample_cnt increments and saturates at all-ones. out_valid=1 whether or not the incumbent is replaced.
  - Otherwise out_valid=0.
- Latency: a beat with in_valid at cycle t updates the outputs, with out_valid visible, at t+L (default L = 6+2+1 = 9).
- Throughput: one beat per cycle; no backpressure.
- Clear:
  - Does not flush the pipeline; beats in flight land after the clear and start the new maximum.
  - Clear held for several cycles loads each arriving sample unconditionally, so the last one wins.
- Arithmetic: signed compare only; no saturation of scores.
- Reset mid-stream discards all in-flight beats immediately.

Test Plan:
- Defaults (N=4, DELAY=6, TIE_MODE=0). One beat at t=10: scores {lane0..3} = {3,-2,7,5}, locations {100,101,102,103}, mask 1111 -> at t=19: out_valid=1, max_out=7, location_out=102, lane_out=2, sample_cnt=1; out_valid=0 at t=18 and t=20.
- Back-to-back beats with max lane scores 4, 9, 9, 2 (the two 9s at locations 50 then 60) -> max_out sequence 4, 9, 9, 9 on consecutive cycles; location_out stays 50 (TIE_MODE=0); sample_cnt reaches 4. Rerun with TIE_MODE=1 -> location_out=60.
- Masking:
  - mask 0001 with lane0=-5 and lane1=100 -> max_out=-5, lane_out=0.
  - mask 0000 with in_valid=1 -> no out_valid, sample_cnt unchanged.
- Clear collision:
  - Running max 20. Assert clear in the cycle a sample of score -3 reaches the tree output -> max_out=-3, sample_cnt=1.
  - Clear with no sample present -> max_out=-32768, location_out=0, sample_cnt=0.
- Intra-tree tie: all lanes score 8, locations {7,8,9,10} -> lane_out=0, location_out=7.
- Reset with 5 beats in flight:
  - All outputs return to reset values asynchronously.
  - No out_valid pulse occurs in the following L cycles after release.
  - Also run with NUM_LANES=1, DELAY=1: L=2, lane_out=0.
